// File: rtl/mem_pkg.sv
// Shared types and widths for the RAM access path (ram_arbiter, ram_256B).
package mem_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_t;

  // One arbitrated request as latched at grant time.
  typedef struct packed {
    port_t             port;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;
endpackage

// File: rtl/arb2_rr.sv
// Two-request round-robin picker; purely combinational, history kept by the caller.
module arb2_rr
  import mem_pkg::*;
(
  input  logic  req_if,
  input  logic  req_d,
  input  port_t last_grant,
  output port_t grant
);
  always_comb begin
    grant = PORT_IF;
    if (req_if && req_d) grant = (last_grant == PORT_D) ? PORT_IF : PORT_D;
    else if (req_d)      grant = PORT_D;
  end
endmodule

// File: rtl/ram_arbiter.sv
// Fetch / load-store arbiter in front of the single-port 256-byte RAM.
// One transaction in flight: IDLE -> ACCESS (1 or RD_LAT+1 cycles) -> DONE (ack).
module ram_arbiter
  import mem_pkg::*;
#(
  parameter int RD_LAT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  localparam logic CNT_LAST = (RD_LAT != 0);

  state_t state, state_nxt;
  port_t  last_grant, grant, lat_port;
  logic   lat_we, cnt, any_req, acc_last;
  req_t   sel;

  arb2_rr u_arb (
    .req_if     (if_req),
    .req_d      (d_req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign any_req  = if_req | d_req;
  // Writes leave ACCESS after one cycle; reads wait out the RAM latency.
  assign acc_last = lat_we | (cnt == CNT_LAST);
  assign ram_we   = (state == ST_ACCESS) & lat_we;

  always_comb begin
    sel = '{port: PORT_IF, we: 1'b0, addr: if_addr, wdata: ram_wdata};
    if (grant == PORT_D) sel = '{port: PORT_D, we: d_we, addr: d_addr, wdata: d_wdata};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (any_req) state_nxt = ST_ACCESS;
      ST_ACCESS: if (acc_last) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= PORT_D;
      lat_port   <= PORT_IF;
      lat_we     <= 1'b0;
      cnt        <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        ST_IDLE: if (any_req) begin
          last_grant <= sel.port;
          lat_port   <= sel.port;
          lat_we     <= sel.we;
          ram_addr   <= sel.addr;
          ram_wdata  <= sel.wdata;
          cnt        <= 1'b0;
        end
        ST_ACCESS: begin
          if (acc_last) begin
            if (lat_port == PORT_IF) begin
              if_ack   <= 1'b1;
              if_rdata <= ram_rdata;
            end else begin
              d_ack <= 1'b1;
              if (!lat_we) d_rdata <= ram_rdata;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
